// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller states and the divide step count.
package mdu_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110,
      MD_RSVD  = 3'b111
   } mdop_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } mdu_state_e;

   localparam int DIV_STEPS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_STEPS);

endpackage

// File: rtl/mdu_if.sv
// Pipeline-side bus of the multiply/divide unit.
//   EX_MDOp/EX_start/EX_A/EX_B : operation request from the EX stage
//   flush                      : kill any in-flight operation
//   isbusy/done                : status back to the stall unit
//   HI/LO                      : architectural result registers
interface mdu_if;
   logic [2:0]  EX_MDOp;
   logic        EX_start;
   logic [31:0] EX_A;
   logic [31:0] EX_B;
   logic        flush;
   logic        isbusy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output EX_MDOp, EX_start, EX_A, EX_B, flush,
      input  isbusy, done, HI, LO
   );

   modport slave (
      input  EX_MDOp, EX_start, EX_A, EX_B, flush,
      output isbusy, done, HI, LO
   );
endinterface

// File: rtl/mdu_div_core.sv
// Restoring divider, one quotient bit per step on operand magnitudes.
//   start_i  : latch operands (signed_i selects DIV vs DIVU)
//   abort_i  : drop the operation, clear the step counter
//   step_i   : perform one restoring step
//   fix_i    : sign-corrected results are presented, valid_o pulses
//   last_o   : the current step is the final one
//   q_o/r_o  : corrected quotient / remainder
module mdu_div_core
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        signed_i,
   input  logic        step_i,
   input  logic        fix_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        last_o,
   output logic        valid_o,
   output logic [31:0] q_o,
   output logic [31:0] r_o
);

   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]          quo_q, quo_d;
   logic [31:0]          rem_q, rem_d;
   logic [31:0]          b_q, b_d;
   logic [31:0]          a_raw_q, a_raw_d;
   logic                 neg_q_q, neg_q_d;
   logic                 neg_r_q, neg_r_d;
   logic                 div0_q, div0_d;

   logic                 a_neg, b_neg;
   logic [32:0]          rem_sh, trial;

   assign a_neg  = signed_i & a_i[31];
   assign b_neg  = signed_i & b_i[31];
   // Dividend bits shift out of the top of quo_q into the partial remainder.
   assign rem_sh = {rem_q, quo_q[31]};
   assign trial  = rem_sh - {1'b0, b_q};

   always_comb begin
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      b_d     = b_q;
      a_raw_d = a_raw_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      div0_d  = div0_q;
      if (abort_i) begin
         cnt_d = '0;
      end else if (start_i) begin
         cnt_d   = '0;
         quo_d   = a_neg ? -a_i : a_i;
         rem_d   = '0;
         b_d     = b_neg ? -b_i : b_i;
         a_raw_d = a_i;
         neg_q_d = a_neg ^ b_neg;
         neg_r_d = a_neg;
         div0_d  = (b_i == 32'd0);
      end else if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         b_q     <= '0;
         a_raw_q <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         b_q     <= b_d;
         a_raw_q <= a_raw_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         div0_q  <= div0_d;
      end
   end

   assign last_o  = step_i && (cnt_q == DIV_CNT_W'(DIV_STEPS - 1));
   assign valid_o = fix_i & ~abort_i;
   // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend.
   // 0x8000_0000 / -1 needs no special case: negating 0x8000_0000 wraps to itself.
   assign q_o = div0_q ? 32'hFFFF_FFFF : (neg_q_q ? -quo_q : quo_q);
   assign r_o = div0_q ? a_raw_q       : (neg_r_q ? -rem_q : rem_q);

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO. MULT/MULTU finish one cycle after
// issue, DIV/DIVU take 32 restoring steps plus a sign fix-up cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mdu_if slave (request, flush, status, HI/LO)
//
// state  | meaning
// IDLE   | accepting requests, MTHI/MTLO write here
// MUL    | product computed, HI/LO written at end of cycle
// DIV    | restoring divide step in progress
// FIX    | sign fix-up, HI/LO written at end of cycle
module mdu
   import mdu_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   mdu_if.slave   bus
);

   mdu_state_e  state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] mul_a_q, mul_b_q;
   logic        mul_s_q;

   mdop_e       op;
   logic        accept, is_mul, is_div;
   logic        div_last, div_valid;
   logic [31:0] div_q, div_r;
   logic signed [65:0] prod;

   assign op     = mdop_e'(bus.EX_MDOp);
   assign accept = (state_q == S_IDLE) & bus.EX_start & ~bus.flush;
   assign is_mul = (op == MD_MULT) | (op == MD_MULTU);
   assign is_div = (op == MD_DIV)  | (op == MD_DIVU);

   // 33-bit extension lets one signed multiplier serve both MULT and MULTU.
   assign prod = $signed({mul_s_q & mul_a_q[31], mul_a_q})
               * $signed({mul_s_q & mul_b_q[31], mul_b_q});

   mdu_div_core u_div (
      .clk      (clk),
      .rst      (rst),
      .start_i  (accept & is_div),
      .abort_i  (bus.flush),
      .signed_i (op == MD_DIV),
      .step_i   (state_q == S_DIV),
      .fix_i    (state_q == S_FIX),
      .a_i      (bus.EX_A),
      .b_i      (bus.EX_B),
      .last_o   (div_last),
      .valid_o  (div_valid),
      .q_o      (div_q),
      .r_o      (div_r)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && is_mul)      state_d = S_MUL;
            else if (accept && is_div) state_d = S_DIV;
         end
         S_MUL:   state_d = S_IDLE;
         S_DIV:   if (div_last) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus.flush) state_d = S_IDLE;
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      bus.done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && op == MD_MTHI) hi_d = bus.EX_A;
            if (accept && op == MD_MTLO) lo_d = bus.EX_A;
         end
         S_MUL: begin
            if (!bus.flush) begin
               {hi_d, lo_d} = prod[63:0];
               bus.done     = 1'b1;
            end
         end
         S_FIX: begin
            if (div_valid) begin
               hi_d     = div_r;
               lo_d     = div_q;
               bus.done = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q    <= '0;
         lo_q    <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         mul_s_q <= 1'b0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (accept && is_mul) begin
            mul_a_q <= bus.EX_A;
            mul_b_q <= bus.EX_B;
            mul_s_q <= (op == MD_MULT);
         end
      end
   end

   assign bus.isbusy = (state_q != S_IDLE);
   assign bus.HI     = hi_q;
   assign bus.LO     = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mdu_if bus ();

   mdu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issuing while busy would be a stall-unit bug; flag it.
   always @(posedge clk) begin
      if (!rst && bus.EX_start && bus.isbusy) begin
         errors++;
         $error("FAIL start_while_busy: observed start=1 expected start=0");
      end
   end

   task automatic idle_bus();
      bus.EX_MDOp  = 3'b000;
      bus.EX_start = 1'b0;
      bus.EX_A     = '0;
      bus.EX_B     = '0;
      bus.flush    = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.EX_MDOp  = op;
      bus.EX_start = 1'b1;
      bus.EX_A     = a;
      bus.EX_B     = b;
      tick();
      idle_bus();
   endtask

   task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int n;
      int done_at;
      int done_cnt;
      issue(op, a, b);
      n = 0; done_at = -1; done_cnt = 0;
      while (bus.isbusy && n < 40) begin
         if (bus.done) begin
            done_at = n;
            done_cnt++;
         end
         n++;
         tick();
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
      chk({tag, "_done_pos"}, 32'(done_at), 32'd32);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_LO"}, bus.LO, exp_lo);
      chk({tag, "_HI"}, bus.HI, exp_hi);
   endtask

   initial begin
      int dn;
      idle_bus();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_HI", bus.HI, 32'h0);
      chk("rst_LO", bus.LO, 32'h0);
      chk("rst_busy", 32'(bus.isbusy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);

      // MULT -2 * 3
      issue(3'b001, 32'hFFFF_FFFE, 32'd3);
      chk("mult_busy", 32'(bus.isbusy), 32'h1);
      chk("mult_done", 32'(bus.done), 32'h1);
      tick();
      chk("mult_busy_after", 32'(bus.isbusy), 32'h0);
      chk("mult_done_after", 32'(bus.done), 32'h0);
      chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
      chk("mult_LO", bus.LO, 32'hFFFF_FFFA);

      // MULTU 0xFFFFFFFF * 2
      issue(3'b010, 32'hFFFF_FFFF, 32'd2);
      chk("multu_done", 32'(bus.done), 32'h1);
      tick();
      chk("multu_HI", bus.HI, 32'h1);
      chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

      run_div("div_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("divu_100_7", 3'b100, 32'd100, 32'd7, 32'd14, 32'd2);
      run_div("div_by0", 3'b011, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      run_div("divu_by0", 3'b100, 32'h8000_0003, 32'd0, 32'hFFFF_FFFF, 32'h8000_0003);
      run_div("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);

      // Flush at step 10 of DIVU: prior HI=0, LO=0x8000_0000
      issue(3'b100, 32'd1000, 32'd3);
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) dn++;
         tick();
      end
      bus.flush = 1'b1;
      #1;
      if (bus.done) dn++;
      tick();
      bus.flush = 1'b0;
      chk("flush_busy", 32'(bus.isbusy), 32'h0);
      for (int i = 0; i < 30; i++) begin
         if (bus.done) dn++;
         tick();
      end
      chk("flush_no_done", 32'(dn), 32'h0);
      chk("flush_HI", bus.HI, 32'h0);
      chk("flush_LO", bus.LO, 32'h8000_0000);

      // Start with flush is ignored
      bus.flush = 1'b1;
      issue(3'b001, 32'd3, 32'd3);
      chk("start_flush_busy", 32'(bus.isbusy), 32'h0);
      tick();
      chk("start_flush_LO", bus.LO, 32'h8000_0000);

      // MTHI then MTLO back-to-back
      bus.EX_MDOp = 3'b101; bus.EX_start = 1'b1; bus.EX_A = 32'h1234;
      tick();
      chk("mthi_busy", 32'(bus.isbusy), 32'h0);
      chk("mthi_HI", bus.HI, 32'h1234);
      bus.EX_MDOp = 3'b110; bus.EX_A = 32'h5678;
      tick();
      idle_bus();
      chk("mtlo_busy", 32'(bus.isbusy), 32'h0);
      chk("mtlo_HI", bus.HI, 32'h1234);
      chk("mtlo_LO", bus.LO, 32'h5678);

      // rst mid-MUL
      issue(3'b001, 32'd3, 32'd5);
      chk("rstmul_busy_pre", 32'(bus.isbusy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmul_HI", bus.HI, 32'h0);
      chk("rstmul_LO", bus.LO, 32'h0);
      chk("rstmul_busy", 32'(bus.isbusy), 32'h0);
      chk("rstmul_done", 32'(bus.done), 32'h0);

      // rst mid-division discards it
      issue(3'b100, 32'd50, 32'd5);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 35; i++) begin
         if (bus.done || bus.isbusy) dn++;
         tick();
      end
      chk("rstdiv_quiet", 32'(dn), 32'h0);
      chk("rstdiv_LO", bus.LO, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have no parameters; the operand width is fixed at 32.
REQ-002 SHALL have port `clk  in  1`: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst  in  1`: the reset, synchronous and active-high.
REQ-004 SHALL have port `EX_MDOp  in  3`: operation code: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-005 SHALL have port `EX_start  in  1`: EX_MDOp is valid and the EX stage advances this cycle.
REQ-006 SHALL have port `EX_A  in  32`: rs operand, already bypassed.
REQ-007 SHALL have port `EX_B  in  32`: rt operand, already bypassed.
REQ-008 SHALL have port `flush  in  1`: MEM_ex | MEM_eret_flush.
REQ-009 SHALL have port `isbusy  out  1`: an operation is in progress; feeds the stall unit.
REQ-010 SHALL have port `done  out  1`: one-cycle pulse in the cycle HI/LO is written by MULT*/DIV*.
REQ-011 SHALL have port `HI  out  32`: architectural HI register.
REQ-012 SHALL have port `LO  out  32`: architectural LO register.

Function
REQ-013 SHALL implement the states IDLE, MUL, DIV and FIX.
REQ-014 SHALL drive isbusy = (state != IDLE), decoded from a register only.
REQ-015 SHALL, in IDLE with EX_start and no flush:
- MULT/MULTU: latch the operands and go to MUL.
- DIV/DIVU: latch the operands and go to DIV with the iteration counter at 0.
- MTHI: HI <= EX_A at this edge, stay in IDLE.
- MTLO: LO <= EX_A at this edge, stay in IDLE.
REQ-016 SHALL, in MUL, compute the 64-bit product (signed for MULT, unsigned for MULTU), write {HI,LO}, pulse done and return to IDLE; MULT* latency is 2 edges from start and isbusy is high for 1 cycle.
REQ-017 SHALL, in DIV, run one restoring step per cycle on operand magnitudes; counter 0..31, wraps to FIX after 32 steps.
REQ-018 SHALL, in FIX, apply the sign corrections (quotient negative iff operand signs differ; remainder takes the dividend sign), write LO=quotient and HI=remainder, pulse done and go to IDLE; DIV* latency is 34 edges and isbusy is high for 33 cycles.
REQ-019 SHALL handle divide by zero without trapping: LO=32'hFFFF_FFFF, HI=EX_A, for both DIV and DIVU.
REQ-020 SHALL give DIV of 32'h8000_0000 by 32'hFFFF_FFFF the result LO=32'h8000_0000, HI=0.
REQ-021 SHALL abort any non-IDLE state to IDLE on flush, leaving HI/LO unchanged and raising no done.
REQ-022 SHALL ignore EX_start in the cycle flush is high.
REQ-023 SHALL ignore EX_start while busy; the stall unit prevents it, and a bench assertion flags any occurrence.
REQ-024 SHALL keep HI/LO stable between writes; a read in the cycle after done sees the new value.

Reset
REQ-025 SHALL, on rst, put state in IDLE, clear the counter, and drive HI=0, LO=0, isbusy=0, done=0.
REQ-026 SHALL give rst priority over flush and EX_start; rst mid-division discards the operation.

Structure
REQ-027 SHALL place the MDOp encodings, the state enum and the constant DIV_STEPS=32 in a shared package, mdu_pkg.
REQ-028 SHALL implement the divide datapath (latched magnitudes, partial remainder, counter, sign fix-up) as one sub-module, mdu_div_core, driven by start/abort and returning a valid pulse; the multiplier stays inline.

Verification
REQ-029 SHALL cover MULT with A=32'hFFFF_FFFE and B=3: isbusy 1 for one cycle -> done, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-030 SHALL cover MULTU with A=32'hFFFF_FFFF and B=2 -> HI=1, LO=32'hFFFF_FFFE after 2 edges.
REQ-031 SHALL cover DIV with A=-7 and B=2 -> isbusy 33 cycles, then LO=-3, HI=-1; DIVU with A=100 and B=7 -> LO=14, HI=2.
REQ-032 SHALL cover DIV with B=0 and A=5 -> LO=32'hFFFF_FFFF, HI=5; DIV of 32'h8000_0000 by -1 -> LO=32'h8000_0000, HI=0.
REQ-033 SHALL cover flush at step 10 of DIVU -> isbusy 0 the next cycle, HI/LO keep their prior values, and no done.
REQ-034 SHALL cover MTHI 32'h1234 then MTLO 32'h5678 back-to-back -> HI=32'h1234, LO=32'h5678, isbusy stays 0; rst mid-MUL -> all outputs 0.
